unified_mem_arbiter: RTL and testbench

// - Shares the single-port unified memory between two requesters: the multicycle core
//   (port 0) and a debug/program-loader master (port 1).
// - Sits between the core's mem_addr/WriteData/MemWrite path and the unified memory.
// - Round-robin arbitration per access, optional bounded lock (burst) ownership.
// - Returns read data with a valid strobe, routed to the requester that issued the read.

---
 rtl/unified_mem_arbiter_pkg.sv | 30 +++
 rtl/unified_mem_arbiter_if.sv | 27 ++
 rtl/unified_mem_arbiter_rr_arb2.sv | 21 ++
 rtl/unified_mem_arbiter.sv | 120 ++++++++++++
 tb/tb_unified_mem_arbiter.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the unified memory arbiter: owner/state encodings,
// port indices and a state-to-owner helper.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_CORE,
      OWN_DBG
   } owner_e;

   typedef enum logic [1:0] {
      IDLE,
      OWN_CORE_S,
      OWN_DBG_S
   } arb_state_e;

   localparam int PORT_CORE = 0;
   localparam int PORT_DBG  = 1;

   function automatic owner_e to_owner(input arb_state_e s);
      owner_e o;
      case (s)
         OWN_CORE_S: o = OWN_CORE;
         OWN_DBG_S:  o = OWN_DBG;
         default:    o = OWN_NONE;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// One requester port of the unified memory arbiter: request/grant
// handshake, write data and the routed read-return path.
interface mem_port_if
   import mem_arb_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          req;
   logic          we;
   logic          lock;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          gnt;
   logic          rvalid;
   logic [DW-1:0] rdata;

   modport master (
      output req, we, lock, addr, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, lock, addr, wdata,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/unified_mem_arbiter_rr_arb2.sv
// Two-request pick: round-robin against the last grant, or fixed
// core priority when rr_en is low.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   input  logic       rr_en,
   output logic [1:0] gnt
);
   always_comb begin
      gnt = req;
      if (&req) begin
         gnt = '0;
         if (rr_en && last == 1'(PORT_CORE))
            gnt[PORT_DBG] = 1'b1;
         else
            gnt[PORT_CORE] = 1'b1;
      end
   end
endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates the single-port unified memory between the core and the
// debug master, with bounded lock ownership and tagged read return.
module unified_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int LOCK_MAX = 8,
   parameter int RR_EN    = 1
) (
   input  logic          clk,
   input  logic          reset,
   mem_port_if.slave     core,
   mem_port_if.slave     dbg,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   input  logic [DW-1:0] mem_rdata,
   output owner_e        owner
);
   localparam int CW = $clog2(LOCK_MAX + 1);

   arb_state_e    state, state_n;
   logic [CW-1:0] lock_cnt, cnt_n, cnt_inc;
   logic          last_gnt, last_n;
   owner_e        rd_tag, tag_n;
   logic [1:0]    req, pick, gnt;
   logic          own_dbg, x_req, x_lock;

   assign req = {dbg.req, core.req};

   rr_arb2 u_rr (
      .req   (req),
      .last  (last_gnt),
      .rr_en (1'(RR_EN)),
      .gnt   (pick)
   );

   assign own_dbg = (state == OWN_DBG_S);
   assign x_req   = own_dbg ? dbg.req  : core.req;
   assign x_lock  = own_dbg ? dbg.lock : core.lock;
   assign cnt_inc = (lock_cnt == CW'(LOCK_MAX)) ? lock_cnt
                                                : lock_cnt + 1'b1;

   always_comb begin
      gnt     = pick;
      state_n = state;
      cnt_n   = lock_cnt;
      last_n  = last_gnt;
      tag_n   = OWN_NONE;
      case (state)
         IDLE: begin
            cnt_n = '0;
            // With LOCK_MAX = 1 the first grant already exhausts the lock
            if (pick[PORT_CORE] && core.lock) begin
               cnt_n = CW'(1);
               if (LOCK_MAX > 1) state_n = OWN_CORE_S;
            end else if (pick[PORT_DBG] && dbg.lock) begin
               cnt_n = CW'(1);
               if (LOCK_MAX > 1) state_n = OWN_DBG_S;
            end
         end
         OWN_CORE_S, OWN_DBG_S: begin
            gnt          = '0;
            gnt[own_dbg] = x_req;
            if (!x_req) begin
               state_n = IDLE;
            end else begin
               cnt_n = cnt_inc;
               if (!x_lock || cnt_inc == CW'(LOCK_MAX))
                  state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
      if (gnt[PORT_CORE]) begin
         last_n = 1'(PORT_CORE);
         if (!core.we) tag_n = OWN_CORE;
      end else if (gnt[PORT_DBG]) begin
         last_n = 1'(PORT_DBG);
         if (!dbg.we) tag_n = OWN_DBG;
      end
   end

   always_comb begin
      mem_addr  = core.addr;
      mem_wdata = core.wdata;
      mem_we    = 1'b0;
      if (gnt[PORT_CORE]) begin
         mem_we = core.we;
      end else if (gnt[PORT_DBG]) begin
         mem_addr  = dbg.addr;
         mem_wdata = dbg.wdata;
         mem_we    = dbg.we;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         owner    <= OWN_NONE;
         lock_cnt <= '0;
         last_gnt <= 1'(PORT_DBG);
         rd_tag   <= OWN_NONE;
      end else begin
         state    <= state_n;
         owner    <= to_owner(state_n);
         lock_cnt <= cnt_n;
         last_gnt <= last_n;
         rd_tag   <= tag_n;
      end
   end

   assign core.gnt    = gnt[PORT_CORE];
   assign dbg.gnt     = gnt[PORT_DBG];
   assign core.rvalid = (rd_tag == OWN_CORE);
   assign dbg.rvalid  = (rd_tag == OWN_DBG);
   assign core.rdata  = mem_rdata;
   assign dbg.rdata   = mem_rdata;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench: round-robin instance with a word memory model, plus a
// fixed-priority LOCK_MAX=1 instance.
module tb_unified_mem_arbiter;
   import mem_arb_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_we;
   owner_e      own1;
   logic [31:0] m2_addr, m2_wdata, rd2;
   logic        m2_we;
   owner_e      own2;
   logic [31:0] mem [256];
   int          n_chk  = 0;
   int          n_pass = 0;

   mem_port_if #(.AW(32), .DW(32)) cb ();
   mem_port_if #(.AW(32), .DW(32)) db ();
   mem_port_if #(.AW(32), .DW(32)) c2 ();
   mem_port_if #(.AW(32), .DW(32)) d2 ();

   always #5 clk = ~clk;
   assign rd2 = '0;

   unified_mem_arbiter #(.AW(32), .DW(32), .LOCK_MAX(8), .RR_EN(1)) u_rr (
      .clk(clk), .reset(reset), .core(cb), .dbg(db),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_rdata(mem_rdata), .owner(own1)
   );

   unified_mem_arbiter #(.AW(32), .DW(32), .LOCK_MAX(1), .RR_EN(0)) u_fp (
      .clk(clk), .reset(reset), .core(c2), .dbg(d2),
      .mem_addr(m2_addr), .mem_wdata(m2_wdata), .mem_we(m2_we),
      .mem_rdata(rd2), .owner(own2)
   );

   // Word memory, 1-cycle read latency
   always @(posedge clk) begin
      if (reset) begin
         mem[4] <= 32'hDEAD_BEEF;
         mem[8] <= 32'hCAFE_F00D;
      end else if (mem_we) begin
         mem[mem_addr[9:2]] <= mem_wdata;
      end
      mem_rdata <= mem[mem_addr[9:2]];
   end

   task automatic check(input string tag, input logic [63:0] act,
                        input logic [63:0] exp);
      n_chk++;
      if (act !== exp)
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      cb.req = 0; cb.we = 0; cb.lock = 0; cb.addr = '0; cb.wdata = '0;
      db.req = 0; db.we = 0; db.lock = 0; db.addr = '0; db.wdata = '0;
      c2.req = 0; c2.we = 0; c2.lock = 0; c2.addr = '0; c2.wdata = '0;
      d2.req = 0; d2.we = 0; d2.lock = 0; d2.addr = '0; d2.wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_owner", own1, OWN_NONE);
      check("rst_crv", cb.rvalid, 1'b0);
      check("rst_drv", db.rvalid, 1'b0);
      check("rst_we", mem_we, 1'b0);
      reset = 1'b0;

      // contention right after reset: core first, then dbg
      cb.req = 1; cb.addr = 32'h10;
      db.req = 1; db.addr = 32'h20;
      #1;
      check("cont_cgnt", cb.gnt, 1'b1);
      check("cont_dgnt0", db.gnt, 1'b0);
      tick();
      cb.req = 0;
      #1;
      check("cont_dgnt", db.gnt, 1'b1);
      check("cont_crv", cb.rvalid, 1'b1);
      check("cont_crd", cb.rdata, 32'hDEAD_BEEF);
      check("cont_drv0", db.rvalid, 1'b0);
      tick();
      db.req = 0;
      check("cont_drv", db.rvalid, 1'b1);
      check("cont_drd", db.rdata, 32'hCAFE_F00D);
      check("cont_crv0", cb.rvalid, 1'b0);

      // core-only read
      cb.req = 1; cb.addr = 32'h10;
      #1;
      check("rd_gnt", cb.gnt, 1'b1);
      check("rd_addr", mem_addr, 32'h10);
      tick();
      cb.req = 0;
      check("rd_crv", cb.rvalid, 1'b1);
      check("rd_crd", cb.rdata, 32'hDEAD_BEEF);
      check("rd_drv0", db.rvalid, 1'b0);

      // dbg write then core read-back
      db.req = 1; db.we = 1; db.addr = 32'h40; db.wdata = 32'h1234_5678;
      #1;
      check("wr_gnt", db.gnt, 1'b1);
      check("wr_we", mem_we, 1'b1);
      check("wr_wd", mem_wdata, 32'h1234_5678);
      check("wr_addr", mem_addr, 32'h40);
      tick();
      db.req = 0; db.we = 0;
      #1;
      check("wr_we1", mem_we, 1'b0);
      cb.req = 1; cb.addr = 32'h40;
      #1;
      check("rb_gnt", cb.gnt, 1'b1);
      tick();
      cb.req = 0;
      check("rb_crv", cb.rvalid, 1'b1);
      check("rb_crd", cb.rdata, 32'h1234_5678);

      // dbg lock for LOCK_MAX cycles with core waiting
      db.req = 1; db.lock = 1; db.addr = 32'h20;
      cb.req = 1; cb.addr = 32'h10;
      for (int i = 0; i < 8; i++) begin
         #1;
         check($sformatf("lk_dgnt%0d", i), db.gnt, 1'b1);
         check($sformatf("lk_cgnt%0d", i), cb.gnt, 1'b0);
         tick();
         if (i == 0) check("lk_own", own1, OWN_DBG);
      end
      #1;
      check("lk9_cgnt", cb.gnt, 1'b1);
      check("lk9_dgnt", db.gnt, 1'b0);
      check("lk9_own", own1, OWN_NONE);
      tick();
      cb.req = 0; db.req = 0; db.lock = 0;

      // reset while core owns the lock with a read in flight
      cb.req = 1; cb.lock = 1; cb.addr = 32'h10;
      #1;
      check("rl_gnt", cb.gnt, 1'b1);
      tick();
      check("rl_own", own1, OWN_CORE);
      reset = 1;
      #1;
      check("rl_gnt2", cb.gnt, 1'b1);
      tick();
      reset = 0; cb.req = 0; cb.lock = 0;
      #1;
      check("rl_own0", own1, OWN_NONE);
      check("rl_crv0", cb.rvalid, 1'b0);
      check("rl_we0", mem_we, 1'b0);

      // fixed priority: core always wins
      c2.req = 1; d2.req = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("fp_cgnt%0d", i), c2.gnt, 1'b1);
         check($sformatf("fp_dgnt%0d", i), d2.gnt, 1'b0);
         tick();
      end

      // LOCK_MAX = 1: lock never takes ownership
      c2.req = 0; d2.lock = 1;
      #1;
      check("l1_dgnt", d2.gnt, 1'b1);
      tick();
      #1;
      check("l1_own", own2, OWN_NONE);
      check("l1_dgnt2", d2.gnt, 1'b1);
      c2.req = 1;
      #1;
      check("l1_cgnt", c2.gnt, 1'b1);
      check("l1_dgnt3", d2.gnt, 1'b0);
      tick();
      c2.req = 0; d2.req = 0; d2.lock = 0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
